// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS-32 main control FSM with a Mem_Ready wait-state handshake.
// Define MC_CTRL_JUMP_EN to build the jump (JEX) path; otherwise opcode 000010 is illegal.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       ALU_Op1,
  output logic       ALU_Op2,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PC_En,
  output logic       IorD,
  output logic       Mem_Req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Illegal_Op,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_r;
  state_t     next_state_s;
  state_t     decode_state_s;
  logic [1:0] alu_op_s;
  logic       pc_en_s;
  logic       mem_req_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       illegal_s;

  // While in reset the outputs show FETCH decoding, with the enables masked below
  assign decode_state_s = reset_n ? state_r : FETCH;

  // State register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state_s = FETCH;
    alu_op_s     = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSrc        = 2'b00;
    pc_en_s      = 1'b0;
    IorD         = 1'b0;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    case (decode_state_s)
      FETCH: begin
        mem_req_s    = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_s   = Mem_Ready;
        pc_en_s      = Mem_Ready;
        next_state_s = Mem_Ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = RTYPEEX;
          OP_BEQ:       next_state_s = BEQEX;
          OP_ADDI:      next_state_s = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         next_state_s = JEX;
`endif
          default: begin
            next_state_s = FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        next_state_s = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req_s    = 1'b1;
        IorD         = 1'b1;
        next_state_s = Mem_Ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_s  = 1'b1;
        MemtoReg     = 1'b1;
        next_state_s = FETCH;
      end
      MEMWR: begin
        mem_req_s    = 1'b1;
        IorD         = 1'b1;
        mem_write_s  = 1'b1;
        next_state_s = Mem_Ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        ALUSrcA      = 1'b1;
        alu_op_s     = 2'b10;
        next_state_s = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write_s  = 1'b1;
        RegDst       = 1'b1;
        next_state_s = FETCH;
      end
      BEQEX: begin
        ALUSrcA      = 1'b1;
        alu_op_s     = 2'b01;
        PCSrc        = 2'b01;
        pc_en_s      = Zero;
        next_state_s = FETCH;
      end
      ADDIEX: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        next_state_s = ADDIWB;
      end
      ADDIWB: begin
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      JEX: begin
        PCSrc        = 2'b10;
        pc_en_s      = 1'b1;
        next_state_s = FETCH;
      end
`endif
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  assign ALU_Op1    = alu_op_s[1];
  assign ALU_Op2    = alu_op_s[0];
  assign PC_En      = pc_en_s & reset_n;
  assign Mem_Req    = mem_req_s & reset_n;
  assign MemWrite   = mem_write_s & reset_n;
  assign IRWrite    = ir_write_s & reset_n;
  assign RegWrite   = reg_write_s & reset_n;
  assign Illegal_Op = illegal_s & reset_n;
  assign State      = state_r;

endmodule
